// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtraction controller.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MAX = 32;

  // Bit counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bi, bo = borrow out.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller around a single fs_cell, LSB first.
// Optional zero flag output enabled by defining SERIAL_SUB_FLAGS_EN.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero
`endif
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic [CW-1:0]    cnt;
  logic             br, cell_d, cell_bo, last;

  fs_cell u_cell (
    .x (a_sh[0]),
    .y (b_sh[0]),
    .bi(br),
    .d (cell_d),
    .bo(cell_bo)
  );

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Result bits enter at the MSB so bit 0 lands in res_sh[0] after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res1
      assign res_nxt = cell_d;
    end else begin : g_resn
      assign res_nxt = {cell_d, res_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working shift registers are private; outputs only update on RUN->DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      zero   <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      a_sh <= a;
      b_sh <= b;
      br   <= bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      br     <= cell_bo;
      res_sh <= res_nxt;
      cnt    <= cnt + CW'(1);
      if (last) begin
        diff <= res_nxt;
        bout <= cell_bo;
`ifdef SERIAL_SUB_FLAGS_EN
        zero <= (res_nxt == '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl at WIDTH 8, 1 and 32 against an arithmetic/timing model.
module tb_serial_sub_ctrl;

  logic        clk, rst_n, bin_in;
  logic [2:0]  start_v;
  logic [31:0] a_in, b_in;
  logic [2:0]  busy_v, done_v, bout_v, zero_v;
  logic [31:0] diff_v [3];

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // model state per instance: phase 0 idle, 1..W run, W+1 done
  int          ph [3];
  logic [31:0] md [3], pd [3];
  logic        mb [3], mz [3], pb [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int W = (g == 0) ? 8 : ((g == 1) ? 1 : 32);
      logic [W-1:0] dw;
      serial_sub_ctrl #(.WIDTH(W)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start_v[g]),
        .a    (a_in[W-1:0]),
        .b    (b_in[W-1:0]),
        .bin  (bin_in),
        .busy (busy_v[g]),
        .done (done_v[g]),
        .diff (dw),
        .bout (bout_v[g])
`ifdef SERIAL_SUB_FLAGS_EN
        ,
        .zero (zero_v[g])
`endif
      );
      assign diff_v[g] = 32'(dw);
`ifndef SERIAL_SUB_FLAGS_EN
      assign zero_v[g] = 1'b0;
`endif
    end
  endgenerate

  function automatic int wof(input int g);
    return (g == 0) ? 8 : ((g == 1) ? 1 : 32);
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s w=%0d got %h want %h at %0t", nm, wof(g), act, exp, $time);
  endtask

  // Advance the model across the coming rising edge using the inputs now applied.
  task automatic model_adv();
    for (int g = 0; g < 3; g++) begin
      int          w;
      logic [63:0] m, aa, bb, full;
      w = wof(g);
      m = (64'd1 << w) - 64'd1;
      if (!rst_n) begin
        ph[g] = 0; md[g] = '0; mb[g] = 1'b0; mz[g] = 1'b0;
      end else if (ph[g] == 0) begin
        if (start_v[g]) begin
          aa    = {32'd0, a_in} & m;
          bb    = {32'd0, b_in} & m;
          full  = aa - bb - {63'd0, bin_in};
          pd[g] = 32'(full & m);
          pb[g] = (aa < bb + {63'd0, bin_in});
          ph[g] = 1;
        end
      end else if (ph[g] == w + 1) begin
        ph[g] = 0;
      end else begin
        ph[g]++;
        if (ph[g] == w + 1) begin
          md[g] = pd[g]; mb[g] = pb[g]; mz[g] = (pd[g] == 32'd0);
        end
      end
    end
  endtask

  task automatic compare();
    for (int g = 0; g < 3; g++) begin
      int w;
      w = wof(g);
      chk("busy", g, 32'(busy_v[g]), 32'(ph[g] >= 1 && ph[g] <= w));
      chk("done", g, 32'(done_v[g]), 32'(ph[g] == w + 1));
      chk("diff", g, diff_v[g], md[g]);
      chk("bout", g, 32'(bout_v[g]), 32'(mb[g]));
`ifdef SERIAL_SUB_FLAGS_EN
      chk("zero", g, 32'(zero_v[g]), 32'(mz[g]));
`endif
    end
  endtask

  task automatic step();
    model_adv();
    @(negedge clk);
    compare();
  endtask

  // One transaction on instance g; returns cycles from accepting edge to done.
  task automatic run_op(input int g, input logic [31:0] av, input logic [31:0] bv,
                        input logic bv_in, output int lat);
    a_in = av; b_in = bv; bin_in = bv_in;
    start_v = 3'b000; start_v[g] = 1'b1;
    step();
    lat = 1;
    start_v = 3'b000;
    a_in = $urandom; b_in = $urandom; bin_in = 1'($urandom);
    while (!done_v[g] && lat < wof(g) + 4) begin
      step();
      lat++;
    end
    chk("latency", g, 32'(lat), 32'(wof(g) + 1));
    step();
  endtask

  initial begin
    int lat, ndone;
    rst_n = 1'b0; start_v = 3'b000; a_in = '0; b_in = '0; bin_in = 1'b0;
    for (int g = 0; g < 3; g++) begin
      ph[g] = 0; md[g] = '0; mb[g] = 1'b0; mz[g] = 1'b0; pd[g] = '0; pb[g] = 1'b0;
    end
    step();
    step();
    for (int g = 0; g < 3; g++) begin
      chk("rst_diff", g, diff_v[g], 32'd0);
      chk("rst_busy", g, 32'(busy_v[g]), 32'd0);
    end
    rst_n = 1'b1;
    step();

    run_op(0, 32'd5, 32'd3, 1'b0, lat);
    chk("lat_5m3", 0, 32'(lat), 32'd9);
    chk("diff_5m3", 0, diff_v[0], 32'h02);
    chk("bout_5m3", 0, 32'(bout_v[0]), 32'd0);
    run_op(0, 32'd3, 32'd5, 1'b0, lat);
    chk("diff_3m5", 0, diff_v[0], 32'hFE);
    chk("bout_3m5", 0, 32'(bout_v[0]), 32'd1);
    run_op(0, 32'hA5, 32'hA5, 1'b0, lat);
    chk("diff_eq", 0, diff_v[0], 32'h00);
    chk("bout_eq", 0, 32'(bout_v[0]), 32'd0);
`ifdef SERIAL_SUB_FLAGS_EN
    chk("zero_eq", 0, 32'(zero_v[0]), 32'd1);
`endif
    run_op(0, 32'd0, 32'd0, 1'b1, lat);
    chk("diff_0m0b", 0, diff_v[0], 32'hFF);
    chk("bout_0m0b", 0, 32'(bout_v[0]), 32'd1);
`ifdef SERIAL_SUB_FLAGS_EN
    chk("zero_0m0b", 0, 32'(zero_v[0]), 32'd0);
`endif

    // abort mid-RUN with an asynchronous reset
    a_in = 32'h12; b_in = 32'h34; bin_in = 1'b1; start_v = 3'b001;
    step();
    start_v = 3'b000;
    for (int i = 0; i < 3; i++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("arst_done", 0, 32'(done_v[0]), 32'd0);
    chk("arst_diff", 0, diff_v[0], 32'd0);
    chk("arst_bout", 0, 32'(bout_v[0]), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    run_op(0, 32'h40, 32'h41, 1'b0, lat);
    chk("diff_post", 0, diff_v[0], 32'hFF);
    chk("bout_post", 0, 32'(bout_v[0]), 32'd1);

    // start held high with changing operands: one done per WIDTH+2 cycles
    ndone = 0;
    start_v = 3'b001;
    for (int i = 0; i < 20; i++) begin
      a_in = $urandom; b_in = $urandom; bin_in = 1'($urandom);
      step();
      if (done_v[0]) ndone++;
    end
    start_v = 3'b000;
    chk("hold_dones", 0, 32'(ndone), 32'd2);
    step();
    step();

    run_op(1, 32'd0, 32'd1, 1'b0, lat);
    chk("lat_w1", 1, 32'(lat), 32'd2);
    chk("diff_w1", 1, diff_v[1], 32'd1);
    chk("bout_w1", 1, 32'(bout_v[1]), 32'd1);
    run_op(2, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, lat);
    chk("diff_w32", 2, diff_v[2], 32'h0000_0001);
    chk("bout_w32", 2, 32'(bout_v[2]), 32'd1);

    for (int i = 0; i < 1000; i++)
      run_op(0, $urandom, $urandom, 1'($urandom), lat);
    for (int i = 0; i < 1000; i++)
      run_op(2, $urandom, $urandom, 1'($urandom), lat);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
